// File: rtl/shift_pkg.sv
// shift_pkg: state encoding, default parameters and counter width helper for shift_frame_ctrl
package shift_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CLKS_PER_BIT = 1;
  localparam int DEF_GAP = 2;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shift_reg_core.sv
// shift_reg_core: right-shifting zero-fill register with parallel load
module shift_reg_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             lsb_out
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= load ? load_data : shift_en ? q >> 1 : q;
  assign lsb_out = q[0];
endmodule

// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: load/shift/gap sequencer driving a serial shift register LSB first
module shift_frame_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int GAP          = DEF_GAP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_valid,
  input  logic [WIDTH-1:0]         tx_data,
  output logic                     tx_ready,
  output logic                     ser_out,
  output logic                     ser_busy,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);
  localparam int BW = $clog2(WIDTH);
  localparam int PW = cw(CLKS_PER_BIT);
  localparam int GW = cw(GAP);
  localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP > 0 ? GAP - 1 : 0);
  state_t state, next;
  logic [PW-1:0] pcnt;
  logic [GW-1:0] gcnt;
  logic hs, tick, eof;
  assign tx_ready = state == ST_IDLE;
  assign ser_busy = state == ST_SHIFT;
  assign hs = tx_valid & tx_ready;
  assign tick = ser_busy && pcnt == P_LAST;
  assign eof = tick && bit_idx == B_LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = (state == ST_IDLE)  ? (hs ? ST_SHIFT : ST_IDLE) :
           (state == ST_SHIFT) ? (eof ? (GAP == 0 ? ST_IDLE : ST_GAP) : ST_SHIFT) :
           (gcnt == G_LAST ? ST_IDLE : ST_GAP);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pcnt       <= '0;
      bit_idx    <= '0;
      gcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= (ser_busy && !tick) ? pcnt + 1'b1 : '0;
      bit_idx    <= (tick && !eof) ? bit_idx + 1'b1 : (ser_busy && !eof) ? bit_idx : '0;
      gcnt       <= (state == ST_GAP && gcnt != G_LAST) ? gcnt + 1'b1 : '0;
      frame_done <= eof;
    end
  // the register drains to zero after the last bit, so its LSB is ser_out directly
  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (hs),
    .shift_en (tick),
    .load_data(tx_data),
    .lsb_out  (ser_out)
  );
endmodule

// File: tb/tb_shift_frame_ctrl.sv
// tb_shift_frame_ctrl: three configurations driven in parallel, checked against a frame-timing model
module tb_shift_frame_ctrl;
  localparam int W = 4;
  localparam int IDLE_T = 1000;
  int cc[3] = '{1, 3, 1};
  int gg[3] = '{2, 2, 0};
  logic clk = 0, reset = 1, tx_valid = 0;
  logic [3:0] tx_data = 0;
  logic rdy[3], so[3], busy[3], fd[3];
  logic [1:0] bi[3];
  bit act[3];
  int t[3];
  logic [3:0] md[3];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shift_frame_ctrl #(.WIDTH(W), .CLKS_PER_BIT(1), .GAP(2)) u0 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy[0]),
    .ser_out(so[0]), .ser_busy(busy[0]), .frame_done(fd[0]), .bit_idx(bi[0]));
  shift_frame_ctrl #(.WIDTH(W), .CLKS_PER_BIT(3), .GAP(2)) u1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy[1]),
    .ser_out(so[1]), .ser_busy(busy[1]), .frame_done(fd[1]), .bit_idx(bi[1]));
  shift_frame_ctrl #(.WIDTH(W), .CLKS_PER_BIT(1), .GAP(0)) u2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy[2]),
    .ser_out(so[2]), .ser_busy(busy[2]), .frame_done(fd[2]), .bit_idx(bi[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      act[k] = 0;
      t[k] = IDLE_T;
    end
  endtask

  // t counts clocks since the accepting edge; frame occupies t < W*C, idle again at t == W*C+G
  task automatic model_edge();
    for (int k = 0; k < 3; k++)
      if (!act[k]) begin
        if (tx_valid) begin
          act[k] = 1;
          t[k] = 0;
          md[k] = tx_data;
        end else t[k] = IDLE_T;
      end else begin
        t[k]++;
        if (t[k] == W * cc[k] + gg[k]) act[k] = 0;
      end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      bit b;
      b = act[k] && t[k] < W * cc[k];
      chk($sformatf("ready%0d", k), rdy[k], !act[k]);
      chk($sformatf("busy%0d", k), busy[k], b);
      chk($sformatf("ser_out%0d", k), so[k], b ? md[k][t[k] / cc[k]] : 1'b0);
      chk($sformatf("bit_idx%0d", k), bi[k], b ? t[k] / cc[k] : 0);
      chk($sformatf("frame_done%0d", k), fd[k], t[k] == W * cc[k]);
    end
  endtask

  task automatic zero_checks(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ser_out%0d", tag, k), so[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
      chk($sformatf("%s_done%0d", tag, k), fd[k], 0);
      chk($sformatf("%s_bit_idx%0d", tag, k), bi[k], 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic do_reset();
    #2 reset = 1;
    model_reset();
    #1 zero_checks("arst");
    #2 reset = 0;
  endtask

  initial begin
    model_reset();
    #1 zero_checks("rst");
    #11 reset = 0;
    #1 for (int k = 0; k < 3; k++) chk($sformatf("rst_ready%0d", k), rdy[k], 1);
    cyc();
    tx_valid = 1;
    tx_data = 4'b1011;
    cyc();
    tx_valid = 0;
    tx_data = 4'($urandom);
    repeat (14) cyc();
    tx_valid = 1;
    tx_data = 4'hA;
    repeat (40) begin
      cyc();
      if (act[0] && t[0] == 0) tx_data = (tx_data == 4'hA) ? 4'h5 : 4'hA;
    end
    tx_valid = 0;
    repeat (16) cyc();
    tx_valid = 1;
    tx_data = 4'b0110;
    cyc();
    tx_valid = 0;
    repeat (2) cyc();
    do_reset();
    cyc();
    tx_valid = 1;
    tx_data = 4'b1001;
    cyc();
    tx_valid = 0;
    repeat (16) cyc();
    repeat (600) begin
      tx_valid = 1'($urandom);
      tx_data = 4'($urandom);
      if ($urandom_range(0, 79) == 0) do_reset();
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
